// File: rtl/and_reduce_sequencer.sv
// and_reduce_sequencer
//
// Purpose: feeds a stream of k-bit words through an external bitwise-AND unit
// and reduces each packet to a single AND result. The running accumulator
// drives operand A, the incoming word drives operand B, and the unit's result
// is registered back into the accumulator on every accepted word. On the last
// word of a packet the reduced value, the word count and a zero flag are
// offered downstream.
//
// Handshakes: a transfer happens on a rising clk edge where valid && ready are
// both high. The producer holds its payload stable while valid is high and
// ready is low. Ready never depends combinationally on valid.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      synchronous active-low reset
//   inValid    upstream word valid
//   inReady    block can accept a word (high in ACCUM)
//   inData     upstream word
//   inLast     marks inData as the final word of the packet
//   andA       operand A to the AND unit (accumulator)
//   andB       operand B to the AND unit (inData pass-through)
//   andC       result from the AND unit (combinational from andA/andB)
//   outValid   reduced result valid (high in DONE)
//   outReady   downstream accepts the result
//   outData    reduced AND of all packet words
//   outCount   number of words in the packet, saturating
//   outZero    high when outData == 0
//   dbg_state  FSM state: 0 = ACCUM, 1 = DONE
module and_reduce_sequencer #(
    parameter int k  = 16,
    parameter int CW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          inValid,
    output logic          inReady,
    input  logic [k-1:0]  inData,
    input  logic          inLast,
    output logic [k-1:0]  andA,
    output logic [k-1:0]  andB,
    input  logic [k-1:0]  andC,
    output logic          outValid,
    input  logic          outReady,
    output logic [k-1:0]  outData,
    output logic [CW-1:0] outCount,
    output logic          outZero,
    output logic          dbg_state
);

    typedef enum logic {
        ACCUM = 1'b0,
        DONE  = 1'b1
    } state_t;

    state_t        state;
    logic [k-1:0]  acc;
    logic [CW-1:0] count;
    logic [CW-1:0] count_inc;

    // Saturating increment: the counter parks at all-ones.
    assign count_inc = (count == {CW{1'b1}}) ? count : count + CW'(1);

    // Operand pass-through to the external AND unit; no gating on inValid.
    assign andA = acc;
    assign andB = inData;

    // Ready is decoded from the state register only.
    assign inReady   = (state == ACCUM);
    assign dbg_state = state;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= ACCUM;
            acc      <= {k{1'b1}};
            count    <= '0;
            outValid <= 1'b0;
            outData  <= '0;
            outCount <= '0;
            outZero  <= 1'b0;
        end else begin
            case (state)
                ACCUM: begin
                    // inReady is high here, so inValid alone marks an accept.
                    if (inValid) begin
                        acc   <= andC;
                        count <= count_inc;
                        if (inLast) begin
                            outData  <= andC;
                            outCount <= count_inc;
                            outZero  <= (andC == '0);
                            outValid <= 1'b1;
                            state    <= DONE;
                        end
                    end
                end
                DONE: begin
                    // Output payload is held until the handshake and kept
                    // afterwards; only the accumulator and count restart.
                    if (outReady) begin
                        outValid <= 1'b0;
                        acc      <= {k{1'b1}};
                        count    <= '0;
                        state    <= ACCUM;
                    end
                end
                default: begin
                    state <= ACCUM;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_and_reduce_sequencer.sv
module tb_and_reduce_sequencer;

    logic clk;
    logic rst_n;

    // Main instance, k=16, CW=8
    logic        in_valid, in_ready, in_last, out_valid, out_ready, out_zero, st;
    logic [15:0] in_data, and_a, and_b, and_c, out_data;
    logic [7:0]  out_count;

    // Saturation instance, k=16, CW=2
    logic        in_valid2, in_ready2, in_last2, out_valid2, out_ready2, out_zero2, st2;
    logic [15:0] in_data2, and_a2, and_b2, and_c2, out_data2;
    logic [1:0]  out_count2;

    int checks;
    int failures;

    // External AND unit models
    assign and_c  = and_a & and_b;
    assign and_c2 = and_a2 & and_b2;

    and_reduce_sequencer #(.k(16), .CW(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .inValid(in_valid), .inReady(in_ready), .inData(in_data), .inLast(in_last),
        .andA(and_a), .andB(and_b), .andC(and_c),
        .outValid(out_valid), .outReady(out_ready), .outData(out_data),
        .outCount(out_count), .outZero(out_zero), .dbg_state(st)
    );

    and_reduce_sequencer #(.k(16), .CW(2)) dut2 (
        .clk(clk), .rst_n(rst_n),
        .inValid(in_valid2), .inReady(in_ready2), .inData(in_data2), .inLast(in_last2),
        .andA(and_a2), .andB(and_b2), .andC(and_c2),
        .outValid(out_valid2), .outReady(out_ready2), .outData(out_data2),
        .outCount(out_count2), .outZero(out_zero2), .dbg_state(st2)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one edge and settle past it; inputs change and outputs are
    // sampled 1 ns after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [15:0] d, input logic l);
        in_valid = v;
        in_data  = d;
        in_last  = l;
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        rst_n     = 1'b0;
        drive(1'b0, 16'h0000, 1'b0);
        out_ready = 1'b0;
        in_valid2 = 1'b0; in_data2 = 16'h0; in_last2 = 1'b0; out_ready2 = 1'b1;

        // Reset state
        step(); step();
        check("rst_out_valid", 32'(out_valid), 32'h0);
        check("rst_out_data",  32'(out_data),  32'h0);
        check("rst_out_count", 32'(out_count), 32'h0);
        check("rst_out_zero",  32'(out_zero),  32'h0);
        check("rst_in_ready",  32'(in_ready),  32'h1);
        check("rst_and_a",     32'(and_a),     32'hFFFF);
        check("rst_state",     32'(st),        32'h0);
        rst_n = 1'b1;

        // Three-word packet
        out_ready = 1'b1;
        drive(1'b1, 16'hFFFF, 1'b0); step();
        drive(1'b1, 16'h0FF0, 1'b0); step();
        check("p1_acc", 32'(and_a), 32'h0FF0);
        drive(1'b1, 16'h3C3C, 1'b1); step();
        drive(1'b0, 16'h0000, 1'b0);
        check("p1_valid", 32'(out_valid), 32'h1);
        check("p1_data",  32'(out_data),  32'h0C30);
        check("p1_count", 32'(out_count), 32'h3);
        check("p1_zero",  32'(out_zero),  32'h0);
        check("p1_ready_done", 32'(in_ready), 32'h0);
        check("p1_state_done", 32'(st), 32'h1);
        step();
        check("p1_valid_after", 32'(out_valid), 32'h0);
        check("p1_ready_after", 32'(in_ready),  32'h1);
        check("p1_data_kept",   32'(out_data),  32'h0C30);
        check("p1_acc_restart", 32'(and_a),     32'hFFFF);

        // Single-word packet
        drive(1'b1, 16'hA5A5, 1'b1);
        check("p2_and_a", 32'(and_a), 32'hFFFF);
        check("p2_and_b", 32'(and_b), 32'hA5A5);
        step();
        drive(1'b0, 16'h0000, 1'b0);
        check("p2_valid", 32'(out_valid), 32'h1);
        check("p2_data",  32'(out_data),  32'hA5A5);
        check("p2_count", 32'(out_count), 32'h1);
        check("p2_zero",  32'(out_zero),  32'h0);
        step();

        // Zero result with downstream back-pressure
        out_ready = 1'b0;
        drive(1'b1, 16'h00F0, 1'b0); step();
        drive(1'b1, 16'h0F00, 1'b1); step();
        drive(1'b1, 16'h1111, 1'b0);   // must be ignored while in DONE
        for (int i = 0; i < 5; i++) begin
            check("p3_valid_hold", 32'(out_valid), 32'h1);
            check("p3_data_hold",  32'(out_data),  32'h0000);
            check("p3_zero_hold",  32'(out_zero),  32'h1);
            check("p3_count_hold", 32'(out_count), 32'h2);
            check("p3_ready_low",  32'(in_ready),  32'h0);
            step();
        end
        out_ready = 1'b1;
        step();
        drive(1'b0, 16'h0000, 1'b0);
        out_ready = 1'b0;
        check("p3_valid_after", 32'(out_valid), 32'h0);
        check("p3_state_after", 32'(st),        32'h0);
        check("p3_acc_clean",   32'(and_a),     32'hFFFF);
        check("p3_count_kept",  32'(out_count), 32'h2);
        step();
        check("p3_single_hs",   32'(out_valid), 32'h0);
        out_ready = 1'b1;

        // Gaps in inValid
        drive(1'b1, 16'h1234, 1'b0); step();
        drive(1'b0, 16'hDEAD, 1'b0); step();
        drive(1'b0, 16'hBEEF, 1'b1); step();
        check("p4_acc_gap", 32'(and_a), 32'h1234);
        drive(1'b1, 16'h1F3F, 1'b1); step();
        drive(1'b0, 16'h0000, 1'b0);
        check("p4_valid", 32'(out_valid), 32'h1);
        check("p4_data",  32'(out_data),  32'h1234);
        check("p4_count", 32'(out_count), 32'h2);
        step();

        // Reset mid-packet
        drive(1'b1, 16'h00FF, 1'b0); step();
        drive(1'b1, 16'hF0F0, 1'b0); step();
        check("p5_acc_pre", 32'(and_a), 32'h00F0);
        drive(1'b0, 16'h0000, 1'b0);
        rst_n = 1'b0; step();
        rst_n = 1'b1;
        check("p5_rst_valid", 32'(out_valid), 32'h0);
        check("p5_rst_count", 32'(out_count), 32'h0);
        check("p5_rst_data",  32'(out_data),  32'h0);
        check("p5_rst_acc",   32'(and_a),     32'hFFFF);
        drive(1'b1, 16'h8001, 1'b1); step();
        drive(1'b0, 16'h0000, 1'b0);
        check("p5_valid", 32'(out_valid), 32'h1);
        check("p5_data",  32'(out_data),  32'h8001);
        check("p5_count", 32'(out_count), 32'h1);
        step();

        // Count saturation on the CW=2 instance
        for (int i = 0; i < 5; i++) begin
            in_valid2 = 1'b1;
            in_data2  = 16'hFFFF;
            in_last2  = (i == 4);
            step();
        end
        in_valid2 = 1'b0;
        in_last2  = 1'b0;
        check("p6_valid", 32'(out_valid2), 32'h1);
        check("p6_count", 32'(out_count2), 32'h3);
        check("p6_data",  32'(out_data2),  32'hFFFF);
        check("p6_zero",  32'(out_zero2),  32'h0);
        step();
        check("p6_valid_after", 32'(out_valid2), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
